data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl.sv | 120 ++++++++++++
 tb/tb_data_mem_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: turns a core cs/ren/wen request into one SRAM access.
// Latency: LATENCY+1 cycles per access, with read data on dout in the first cycle ram_stall is low.
// Backpressure: ram_stall holds the core for LATENCY cycles; DONE is a one-cycle gap between accesses.
module data_mem_ctrl #(
    parameter int unsigned LATENCY = 3,
    parameter int unsigned AW      = 30
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cs,
    input  logic          ren,
    input  logic          wen,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   din,
    output logic [31:0]   dout,
    output logic          ram_stall,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [31:0]   m_din,
    input  logic [31:0]   m_dout
);

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          wr_q, wr_d;
    logic [31:0]   dout_q, dout_d;
    logic [AW-1:0] m_addr_q, m_addr_d;
    logic [31:0]   m_din_q, m_din_d;

    logic req;
    logic stall_c;
    logic en_c;
    logic we_c;

    // ren and wen together resolve to a write
    assign req = cs & (ren | wen);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        dout_d   = dout_q;
        m_addr_d = m_addr_q;
        m_din_d  = m_din_q;
        stall_c  = 1'b0;
        en_c     = 1'b0;
        we_c     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    stall_c  = 1'b1;
                    state_d  = BUSY;
                    cnt_d    = CNT_LOAD;
                    wr_d     = wen;
                    m_addr_d = addr;
                    m_din_d  = din;
                end
            end
            BUSY: begin
                stall_c = 1'b1;
                // The counter still holds its load value only in the first BUSY cycle
                if (cnt_q == CNT_LOAD) begin
                    en_c = 1'b1;
                    we_c = wr_q;
                end
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = DONE;
                    if (!wr_q) begin
                        dout_d = m_dout;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            wr_q     <= 1'b0;
            dout_q   <= 32'd0;
            m_addr_q <= '0;
            m_din_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            dout_q   <= dout_d;
            m_addr_q <= m_addr_d;
            m_din_q  <= m_din_d;
        end
    end

    // Gated by rst so nothing reaches the core or SRAM while reset is held
    assign ram_stall = rst & stall_c;
    assign m_en      = rst & en_c;
    assign m_we      = rst & we_c;
    assign dout      = dout_q;
    assign m_addr    = m_addr_q;
    assign m_din     = m_din_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed and random accesses against a transaction-level model.
module tb_data_mem_ctrl;

    localparam int LAT = 3;
    localparam int AW  = 30;

    logic          clk;
    logic          rst;
    logic          cs;
    logic          ren;
    logic          wen;
    logic [AW-1:0] addr;
    logic [31:0]   din;
    logic [31:0]   dout;
    logic          ram_stall;
    logic          m_en;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_din;
    logic [31:0]   m_dout;

    int checks = 0;
    int errors = 0;

    logic [31:0] sram      [256];
    logic [31:0] model_mem [256];
    logic [31:0] model_dout;

    data_mem_ctrl #(.LATENCY(LAT), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cs        (cs),
        .ren       (ren),
        .wen       (wen),
        .addr      (addr),
        .din       (din),
        .dout      (dout),
        .ram_stall (ram_stall),
        .m_en      (m_en),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_din     (m_din),
        .m_dout    (m_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous SRAM: read data appears the cycle after m_en
    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) sram[m_addr[7:0]] <= m_din;
            else      m_dout <= sram[m_addr[7:0]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete access; junk scrambles the core inputs once the request is accepted
    task automatic access(input logic do_wr, input logic both, input logic [7:0] a,
                          input logic [31:0] d, input bit junk);
        logic [31:0] exp_dout;
        exp_dout = do_wr ? model_dout : model_mem[a];
        for (int k = 0; k <= LAT; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                cs   = 1'b1;
                ren  = !do_wr || both;
                wen  = do_wr;
                addr = AW'(a);
                din  = d;
            end else if (junk) begin
                cs   = 1'($urandom);
                ren  = 1'($urandom);
                wen  = 1'($urandom);
                addr = AW'($urandom);
                din  = $urandom;
            end
            @(negedge clk);
            check("ram_stall", 32'(ram_stall), (k < LAT) ? 32'd1 : 32'd0);
            check("m_en", 32'(m_en), (k == 1) ? 32'd1 : 32'd0);
            if (k == 1) begin
                check("m_we", 32'(m_we), 32'(do_wr));
                check("m_addr", 32'(m_addr), 32'(a));
                if (do_wr) check("m_din", m_din, d);
            end
            if (k == LAT) check("dout", dout, exp_dout);
        end
        if (do_wr) model_mem[a] = d;
        model_dout = exp_dout;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            cs   = 1'b0;
            ren  = 1'b1;
            wen  = 1'b1;
            addr = AW'($urandom);
            din  = $urandom;
            @(negedge clk);
            check("idle_stall", 32'(ram_stall), 32'd0);
            check("idle_m_en", 32'(m_en), 32'd0);
            check("idle_dout", dout, model_dout);
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  a;
        bit          wr;

        for (int i = 0; i < 256; i++) begin
            model_mem[i] = $urandom;
            sram[i]      = model_mem[i];
        end
        m_dout     = 32'd0;
        model_dout = 32'd0;

        // Reset held with a live request: no stall, no SRAM activity
        rst  = 1'b0;
        cs   = 1'b1;
        ren  = 1'b1;
        wen  = 1'b0;
        addr = '0;
        din  = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall", 32'(ram_stall), 32'd0);
        check("rst_m_en", 32'(m_en), 32'd0);
        check("rst_m_we", 32'(m_we), 32'd0);
        check("rst_dout", dout, 32'd0);
        check("rst_m_addr", 32'(m_addr), 32'd0);
        check("rst_m_din", m_din, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        cs  = 1'b0;

        // Directed read of a known word
        sram[8'h10]      = 32'hDEADBEEF;
        model_mem[8'h10] = 32'hDEADBEEF;
        access(1'b0, 1'b0, 8'h10, 32'd0, 1'b0);

        // Write then read back; the write leaves dout alone
        access(1'b1, 1'b0, 8'h20, 32'h12345678, 1'b0);
        access(1'b0, 1'b0, 8'h20, 32'd0, 1'b0);

        // Back-to-back reads with the request held through DONE
        access(1'b0, 1'b0, 8'h01, 32'd0, 1'b0);
        access(1'b0, 1'b0, 8'h02, 32'd0, 1'b0);

        // Requests without chip-select do nothing
        idle_cycles(5);

        // ren and wen together act as a write
        access(1'b1, 1'b1, 8'h30, 32'hA5A5A5A5, 1'b0);
        access(1'b0, 1'b0, 8'h30, 32'd0, 1'b0);

        // Reset during the second BUSY cycle of a read aborts it
        @(posedge clk); #1;
        cs   = 1'b1;
        ren  = 1'b1;
        wen  = 1'b0;
        addr = AW'(8'h05);
        @(negedge clk);
        check("abort_acc_stall", 32'(ram_stall), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_busy_m_en", 32'(m_en), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_rst_stall", 32'(ram_stall), 32'd0);
        check("abort_rst_m_en", 32'(m_en), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        cs  = 1'b0;
        @(negedge clk);
        model_dout = 32'd0;
        check("abort_dout", dout, 32'd0);
        check("abort_stall", 32'(ram_stall), 32'd0);
        check("abort_m_en", 32'(m_en), 32'd0);
        check("abort_m_addr", 32'(m_addr), 32'd0);
        idle_cycles(2);
        access(1'b0, 1'b0, 8'h05, 32'd0, 1'b0);

        // Random traffic with scrambled inputs during BUSY and occasional gaps
        for (int n = 0; n < 60; n++) begin
            wr = 1'($urandom);
            a  = 8'($urandom_range(0, 63));
            d  = $urandom;
            access(wr, 1'($urandom), a, d, 1'b1);
            if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
